regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x64 register file between N_REQ requesters, e.g. the ALU writeback path and the load path. Arbitration is round-robin with a per-requester valid/ready handshake. The winning write is registered onto the register file write-port signals; the file's write decoder drives the per-bit enable flops from those signals. Writes to the hardwired zero register are accepted and discarded.

Parameters:
N_REQ, 2, number of requesters; legal range 2..4
DATA_W, 64, write data width
ADDR_W, 5, register address width
ZERO_REG, 31, register index that is never written

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  requester i has a pending write
req_addr  input  N_REQ*ADDR_W  destination register of requester i; slice i is [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  write data of requester i; slice i is [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  one-hot or zero; requester i is accepted this cycle
rf_hold  input  1  blocks all acceptances, e.g. while the file is under test access
rf_wr_en  output  1  RegWrite to the register file
rf_wr_addr  output  ADDR_W  WriteRegister
rf_wr_data  output  DATA_W  WriteData
grant_id  output  2  index of the last accepted requester; diagnostic only

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: ptr=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0.
- During any cycle with reset high, req_ready is all-zero. No request is accepted in a reset cycle, including a reset that arrives mid-stream.
- Handshake: a transfer occurs on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
- A requester holds valid, addr and data stable until its transfer; the arbiter need not tolerate valid dropping early.
- req_ready is combinational from req_valid, ptr, rf_hold and reset. It never depends on the ready outputs themselves.
- Arbitration: if rf_hold=0, the winner is the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo N_REQ. req_ready[winner]=1 and all other ready bits are 0.
- No valid request, or rf_hold=1: req_ready=0 and ptr is unchanged.
- Pointer update: on a transfer, ptr <= (winner+1) mod N_REQ and grant_id <= winner. Otherwise ptr holds.
- Fairness: with all N_REQ requesters continuously valid, grants rotate strictly. No requester waits more than N_REQ-1 accepted transfers.
- Latency: exactly 1 cycle. A transfer at edge k makes rf_wr_en=1 with that addr and data during cycle k+1, so the file writes at edge k+1.
- rf_wr_en is high for exactly one cycle per non-zero-register transfer.
- Back-to-back transfers produce back-to-back rf_wr_en pulses, giving a throughput of one write per cycle.
- Zero register: a transfer with addr==ZERO_REG completes the handshake and advances ptr. The next cycle has rf_wr_en=0, and rf_wr_addr and rf_wr_data keep their previous values.
- No transfer in a cycle: rf_wr_en=0 next cycle; addr and data hold.
- rf_hold asserted: no transfer; rf_wr_en=0 in the following cycle. A write already registered (from the transfer before hold rose) still completes.
- Same-address contention: two requesters targeting the same register are serialised in grant order. The later grant overwrites; the arbiter does no merging or forwarding.
- All outputs are registered except req_ready.

Decomposition:
- Package regfile_pkg: DATA_W, ADDR_W, NUM_REGS=32, ZERO_REG=31 constants. It also holds the typedef wr_req_t, a packed struct {addr, data}, used by the register file top level.
- Sub-module rr_arbiter (parameter N): inputs clk, reset, req[N], en; outputs gnt[N] (one-hot) and gnt_idx. It owns the ptr register.
- regfile_write_arbiter instantiates one rr_arbiter with en=~rf_hold. It adds the output stage and the ZERO_REG filter.

Test Plan:
1. Reset hold: hold reset for 3 cycles with req_valid=2'b11 -> req_ready=0 throughout; rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0; first grant after reset goes to requester 0.
2. Single write: req0 = (addr 5, data 64'hDEAD_BEEF_0000_0001), valid for one cycle -> req_ready[0]=1 that cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=64'hDEAD_BEEF_0000_0001; the cycle after, rf_wr_en=0.
3. Contention: both valid continuously for 6 cycles with req0 addr 1 and req1 addr 2 -> grants go 0,1,0,1,0,1; rf_wr_addr sequence is 1,2,1,2,1,2 on consecutive cycles.
4. Zero register: req1 addr 31, data 64'hFFFF followed by req0 addr 3, data 64'h7 -> both handshakes complete; only one rf_wr_en pulse, with addr 3 and data 64'h7; ptr advanced past requester 1.
5. Hold: both valid, then raise rf_hold for 4 cycles -> req_ready=0 and rf_wr_en=0 during the hold (after any in-flight write completes); ptr is frozen; on release, the requester next in rotation is granted.
6. Reset mid-stream: both valid, then assert reset for 1 cycle right after a grant to requester 1 -> the registered write is cleared (rf_wr_en=0 next cycle); after reset, requester 0 is granted first.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write request record.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, rotating priority pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [1:0]   gnt_idx
);
  logic [1:0] ptr;
  logic       found;
  int         off;

  // First requester at or after ptr (wrapping) wins; nothing wins in reset or when disabled.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    off     = 0;
    if (!reset && en) begin
      for (int k = 0; k < N; k++) begin
        off = int'(ptr) + k;
        if (off >= N) off = off - N;
        for (int i = 0; i < N; i++) begin
          if (!found && req[i] && (i == off)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = 2'(i);
          end
        end
      end
    end
  end

  // Priority moves to the requester after the winner; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (|gnt)
      ptr <= (gnt_idx == 2'(N-1)) ? 2'd0 : gnt_idx + 2'd1;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among N_REQ requesters; one registered write per cycle.
module regfile_write_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    rf_hold,
  output logic                    rf_wr_en,
  output logic [ADDR_W-1:0]       rf_wr_addr,
  output logic [DATA_W-1:0]       rf_wr_data,
  output logic [1:0]              grant_id
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sel_t;

  logic [N_REQ-1:0] gnt;
  logic [1:0]       gnt_idx;
  sel_t             sel;
  logic             xfer;
  logic             keep;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (~rf_hold),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  // One-hot mux of the winning request's address and data.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) sel = {req_addr[i*ADDR_W +: ADDR_W], req_data[i*DATA_W +: DATA_W]};
  end

  // Zero-register writes complete the handshake but never reach the file.
  assign keep = xfer && (sel.addr != ADDR_W'(ZERO_REG));

  // Write-port stage: enable pulses one cycle per kept transfer; addr/data hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      grant_id   <= '0;
    end else begin
      rf_wr_en <= keep;
      if (keep) begin
        rf_wr_addr <= sel.addr;
        rf_wr_data <= sel.data;
      end
      if (xfer) grant_id <= gnt_idx;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table plus random sequence, scoreboarded outputs.
module tb_regfile_write_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [9:0]   req_addr;
  logic [127:0] req_data;
  logic [1:0]   req_ready;
  logic         rf_hold;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [63:0]  rf_wr_data;
  logic [1:0]   grant_id;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_hold(rf_hold),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .grant_id(grant_id)
  );

  typedef struct {
    logic        rst, hold;
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    logic [1:0]  rdy;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  a;
    logic [63:0] d;
    logic [1:0]  g;
  } out_t;

  vec_t tbl[$];
  out_t sb[$];
  out_t m;
  int   total = 0;
  int   bad   = 0;
  logic mptr;

  function automatic vec_t mk(logic rst, logic hold, logic [1:0] v, logic [4:0] a0, logic [63:0] d0,
                              logic [4:0] a1, logic [63:0] d1, logic [1:0] rdy);
    vec_t t;
    t.rst = rst; t.hold = hold; t.v = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.rdy = rdy;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check ready, push expected registered outputs, clock, pop and compare.
  task automatic apply(vec_t t);
    out_t e;
    logic w;
    logic [4:0] a;
    reset = t.rst; rf_hold = t.hold; req_valid = t.v;
    req_addr = {t.a1, t.a0}; req_data = {t.d1, t.d0};
    #1;
    chk("req_ready", 64'(req_ready), 64'(t.rdy));
    if (t.rst) begin
      m.en = 1'b0; m.a = '0; m.d = '0; m.g = '0; mptr = 1'b0;
    end else if (t.rdy != 2'b00) begin
      w = t.rdy[1];
      a = w ? t.a1 : t.a0;
      m.g = {1'b0, w};
      mptr = ~w;
      if (a != 5'd31) begin
        m.en = 1'b1; m.a = a; m.d = w ? t.d1 : t.d0;
      end else m.en = 1'b0;
    end else m.en = 1'b0;
    sb.push_back(m);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk("rf_wr_en",   64'(rf_wr_en),   64'(e.en));
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(e.a));
      chk("rf_wr_data", rf_wr_data,      e.d);
      chk("grant_id",   64'(grant_id),   64'(e.g));
    end
  endtask

  initial begin
    logic [1:0]  pv;
    logic [4:0]  pa0, pa1;
    logic [63:0] pd0, pd1;
    vec_t t;
    reset = 1'b1; rf_hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    m = '{en: 1'b0, a: '0, d: '0, g: '0};
    mptr = 1'b0;
    @(posedge clk); #1;

    // Reset hold with both valid
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 2'b11, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd9, 64'h99, 2'b00));
    // First grant goes to 0, then the single write drains, then 1
    tbl.push_back(mk(0, 0, 2'b11, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd9, 64'h99, 2'b01));
    tbl.push_back(mk(0, 0, 2'b10, 5'd0, 64'h0, 5'd9, 64'h99, 2'b10));
    tbl.push_back(mk(0, 0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00));
    tbl.push_back(mk(0, 0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00));
    // Contention: strict alternation
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 2'b11, 5'd1, 64'h10, 5'd2, 64'h20, (i % 2 == 0) ? 2'b01 : 2'b10));
    tbl.push_back(mk(0, 0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00));
    // Zero register: accepted, no write, ptr moves past requester 1
    tbl.push_back(mk(0, 0, 2'b10, 5'd0, 64'h0, 5'd31, 64'hFFFF, 2'b10));
    tbl.push_back(mk(0, 0, 2'b11, 5'd3, 64'h7, 5'd4, 64'h44, 2'b01));
    tbl.push_back(mk(0, 0, 2'b10, 5'd0, 64'h0, 5'd4, 64'h44, 2'b10));
    tbl.push_back(mk(0, 0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00));
    // Hold: in-flight write completes, ptr frozen, rotation resumes
    tbl.push_back(mk(0, 0, 2'b11, 5'd6, 64'h66, 5'd7, 64'h77, 2'b01));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 2'b11, 5'd6, 64'h66, 5'd7, 64'h77, 2'b00));
    tbl.push_back(mk(0, 0, 2'b11, 5'd6, 64'h66, 5'd7, 64'h77, 2'b10));
    tbl.push_back(mk(0, 0, 2'b01, 5'd6, 64'h66, 5'd0, 64'h0, 2'b01));
    tbl.push_back(mk(0, 0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00));
    // Reset mid-stream: after a grant to 1, and with ptr pointing at 1
    tbl.push_back(mk(0, 0, 2'b11, 5'd8, 64'h88, 5'd9, 64'h99, 2'b10));
    tbl.push_back(mk(1, 0, 2'b11, 5'd8, 64'h88, 5'd9, 64'h99, 2'b00));
    tbl.push_back(mk(0, 0, 2'b11, 5'd8, 64'h88, 5'd9, 64'h99, 2'b01));
    tbl.push_back(mk(1, 0, 2'b10, 5'd0, 64'h0, 5'd9, 64'h99, 2'b00));
    tbl.push_back(mk(0, 0, 2'b11, 5'd10, 64'hA0, 5'd9, 64'h99, 2'b01));
    tbl.push_back(mk(0, 0, 2'b10, 5'd0, 64'h0, 5'd9, 64'h99, 2'b10));
    tbl.push_back(mk(0, 0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00));

    foreach (tbl[i]) apply(tbl[i]);

    // Random sequence: requesters hold until accepted, expected grant from a rotation model
    pv = '0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 300; c++) begin
      if (!pv[0] && $urandom_range(0, 2) != 0) begin
        pv[0] = 1'b1; pa0 = 5'($urandom_range(0, 31)); pd0 = {$urandom, $urandom};
      end
      if (!pv[1] && $urandom_range(0, 2) != 0) begin
        pv[1] = 1'b1; pa1 = 5'($urandom_range(0, 31)); pd1 = {$urandom, $urandom};
      end
      t = mk(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), pv, pa0, pd0, pa1, pd1, 2'b00);
      if (!t.rst && !t.hold) begin
        if (pv[mptr])       t.rdy = mptr ? 2'b10 : 2'b01;
        else if (pv[~mptr]) t.rdy = mptr ? 2'b01 : 2'b10;
      end
      apply(t);
      pv = pv & ~t.rdy;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before limit");
    $fatal(1);
  end
endmodule
